// File: rtl/ones_pkg.sv
// Shared definitions for the count-ones datapath: FSM state type and the
// width helpers used by both the count-ones stage and the frame accumulator.
package ones_pkg;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_e;

    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic int unsigned sum_width(input int unsigned width,
                                              input int unsigned frame_len);
        return $clog2(width * frame_len + 1);
    endfunction

    function automatic int unsigned words_width(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/ones_frame_accumulator.sv
// Sums per-word popcounts over frames of up to FRAME_LEN words and presents
// the frame total, word count and threshold flag on a registered handshake.
module ones_frame_accumulator
    import ones_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned THRESHOLD = WIDTH * FRAME_LEN / 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic [count_width(WIDTH)-1:0]             in_count,
    input  logic                                      in_last,
    output logic                                      in_ready,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [sum_width(WIDTH, FRAME_LEN)-1:0]    out_sum,
    output logic [words_width(FRAME_LEN)-1:0]         out_words,
    output logic                                      out_above,
    output logic                                      err
);

    localparam int unsigned CW = count_width(WIDTH);
    localparam int unsigned SW = sum_width(WIDTH, FRAME_LEN);
    localparam int unsigned NW = words_width(FRAME_LEN);

    localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);
    localparam logic [NW-1:0] LEN_W     = NW'(FRAME_LEN);
    localparam logic [SW:0]   THR_W     = (SW + 1)'(THRESHOLD);

    state_e        state_q;
    logic [SW-1:0] acc_q;
    logic [NW-1:0] words_q;
    logic          out_valid_q;
    logic [SW-1:0] out_sum_q;
    logic [NW-1:0] out_words_q;
    logic          out_above_q;
    logic          err_q;

    logic          fire;
    logic          bad_count;
    logic [CW-1:0] count_c;
    logic [SW-1:0] acc_d;
    logic [NW-1:0] words_d;
    logic          close;
    logic          above_d;

    assign in_ready = (state_q == ACCUM) || out_ready;
    assign fire     = in_valid && in_ready;

    // acc/words are always zero in HOLD, so one adder serves both the
    // in-frame beat and the first beat of a frame accepted during HOLD.
    always_comb begin
        bad_count = in_count > COUNT_MAX;
        count_c   = bad_count ? COUNT_MAX : in_count;
        acc_d     = acc_q + SW'(count_c);
        words_d   = words_q + NW'(1);
        close     = in_last || (words_d == LEN_W);
        above_d   = {1'b0, acc_d} > THR_W;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            words_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_words_q <= '0;
            out_above_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (fire && bad_count) begin
                err_q <= 1'b1;
            end
            if (state_q == HOLD && out_ready && !fire) begin
                out_valid_q <= 1'b0;
                state_q     <= ACCUM;
            end else if (fire) begin
                if (close) begin
                    out_valid_q <= 1'b1;
                    out_sum_q   <= acc_d;
                    out_words_q <= words_d;
                    out_above_q <= above_d;
                    acc_q       <= '0;
                    words_q     <= '0;
                    state_q     <= HOLD;
                end else begin
                    out_valid_q <= 1'b0;
                    acc_q       <= acc_d;
                    words_q     <= words_d;
                    state_q     <= ACCUM;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_words = out_words_q;
    assign out_above = out_above_q;
    assign err       = err_q;

endmodule
